imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot loader that fills the instruction memory from a byte stream before the single-cycle core runs.
//   Accepts length-prefixed, checksummed image bytes; assembles little-endian 32-bit words.
//   Drives the IMEM write port and holds the core in reset until the image is verified.
//   Sits upstream of the core: IMEM write side plus core_rst_n generation.
// PARAMETERS
//   IMEM_DEPTH  256  IMEM size in 32-bit words; max accepted image length
//   ADDR_W      8    word-address width, = clog2(IMEM_DEPTH)
// PORTS
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous, active-low reset
//   start        in   1       1-cycle pulse: arm a load (honoured only in IDLE, DONE, ERROR)
//   s_valid      in   1       byte stream valid
//   s_data       in   8       byte stream data
//   s_ready      out  1       loader accepts byte this cycle (transfer = s_valid & s_ready)
//   imem_we      out  1       IMEM word write strobe, 1 cycle per word
//   imem_addr    out  ADDR_W  IMEM word address (byte address = imem_addr<<2)
//   imem_wdata   out  32      IMEM write data
//   core_rst_n   out  1       active-low reset to core; 1 only in DONE
//   load_done    out  1       level: image loaded and checksum matched
//   load_err     out  1       level: length overflow or checksum mismatch
//   words_loaded out  ADDR_W+1 count of words written in current load
// BEHAVIOUR
//   Reset: state=IDLE; s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0,
//     load_done=0, load_err=0, words_loaded=0. All outputs registered.
//   Stream format: LEN[7:0], LEN[15:8], then LEN words x 4 bytes (LSB first),
//     then CSUM 4 bytes (LSB first); CSUM = sum of all data words mod 2^32.
//   States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
//   - IDLE/DONE/ERROR --start--> LEN_LO; clears counters, byte index, running sum,
//     load_done, load_err; core_rst_n=0 from the next cycle.
//   - LEN_LO --byte--> LEN_HI. LEN_HI --byte--> DATA if 0<LEN<=IMEM_DEPTH;
//     CSUM if LEN==0; ERROR if LEN>IMEM_DEPTH (nothing written).
//   - DATA: byte index 0..3; 4th byte completes word; next cycle imem_we=1 with
//     imem_addr=word index, imem_wdata=word; words_loaded increments same cycle;
//     sum += word. After word LEN-1 accepted -> CSUM.
//   - CSUM: after 4th byte compare with sum -> DONE (match) or ERROR (mismatch).
//   - start outside IDLE/DONE/ERROR ignored; bytes in IDLE/DONE/ERROR not accepted.
//   s_ready = 1 in LEN_LO, LEN_HI, DATA, CSUM, else 0; never depends on s_valid.
//     s_valid gaps stall byte assembly only; no byte dropped or duplicated.
//   Writes are fire-and-forget (IMEM accepts a write every cycle); back-to-back
//     words yield imem_we at most once per 4 cycles.
//   DONE: core_rst_n=1 and load_done=1 from the cycle after entering DONE.
//   ERROR: load_err=1, core_rst_n stays 0; IMEM contents undefined.
//   Reset mid-load: immediate return to reset state; partial word discarded;
//     any imem_we in flight is deasserted asynchronously.
//   imem_addr holds last written address between writes; imem_we=0 when idle.
// TESTING
//   1. start; bytes 02 00 | 13 00 50 00 | 93 00 A0 00 | A6 00 F0 00 -> two writes:
//      addr0=0x00500013, addr1=0x00A00093; load_done=1, core_rst_n=1, words_loaded=2.
//   2. Same image, last CSUM byte 0x01 -> load_err=1, load_done=0, core_rst_n=0.
//   3. LEN=0x0101 (257 > 256) -> ERROR right after LEN_HI, imem_we never asserted.
//   4. LEN=0, CSUM=00000000 -> DONE, words_loaded=0, no writes.
//   5. Case 1 with random s_valid gaps (1-5 idle cycles) -> identical writes and result.
//   6. rst_n low after 6 data bytes -> all outputs at reset values; new start + case 1 passes.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte image, writes
// little-endian 32-bit words into IMEM and releases core reset on success.
module imem_loader #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CSUM   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;

    localparam logic [15:0] DEPTH16 = 16'(IMEM_DEPTH);

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       buf_q, buf_d;
    logic [31:0]       sum_q, sum_d;
    logic              s_ready_q, s_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;

    logic        accept;
    logic [31:0] word;
    logic [15:0] len16;

    assign accept = s_valid & s_ready_q;
    // Bytes shift in from the top, so after three bytes buf_q = {b2,b1,b0}.
    assign word   = {s_data, buf_q};
    assign len16  = {s_data, len_lo_q};

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        bidx_d   = bidx_q;
        buf_d    = buf_q;
        sum_d    = sum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wcnt_d   = wcnt_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = LEN_LO;
                    wcnt_d  = '0;
                    bidx_d  = '0;
                    sum_d   = '0;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_lo_d = s_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    bidx_d = '0;
                    if (len16 == 16'd0) begin
                        state_d = CSUM;
                    end else if (len16 > DEPTH16) begin
                        state_d = ERROR;
                    end else begin
                        len_d   = len16[ADDR_W:0];
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wcnt_q[ADDR_W-1:0];
                        wdata_d = word;
                        wcnt_d  = wcnt_q + 1'b1;
                        sum_d   = sum_q + word;
                        if (wcnt_q + 1'b1 == len_q) begin
                            state_d = CSUM;
                        end
                    end else begin
                        buf_d = {s_data, buf_q[23:8]};
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        state_d = (word == sum_q) ? DONE : ERROR;
                    end else begin
                        buf_d = {s_data, buf_q[23:8]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flops track the next state so they line up with state_q.
        s_ready_d    = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                       (state_d == DATA)   || (state_d == CSUM);
        core_rst_n_d = (state_d == DONE);
        done_d       = (state_d == DONE);
        err_d        = (state_d == ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            bidx_q       <= '0;
            buf_q        <= '0;
            sum_q        <= '0;
            s_ready_q    <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            bidx_q       <= bidx_d;
            buf_q        <= buf_d;
            sum_q        <= sum_d;
            s_ready_q    <= s_ready_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            err_q        <= err_d;
            wcnt_q       <= wcnt_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_rst_n   = core_rst_n_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good image, bad checksum, oversize length,
// empty image, stalled stream, and reset in the middle of a load.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        load_done;
    logic        load_err;
    logic [8:0]  words_loaded;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  img[$];
    logic [7:0]  wa[$];
    logic [31:0] wd[$];

    imem_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst_n   (core_rst_n),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("byte_timeout", 32'(n), 32'd0);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_img(input int maxgap, input int start_at);
        for (int i = 0; i < img.size(); i++) begin
            if (i == start_at) pulse_start();
            send_byte(img[i], (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
        end
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(load_done || load_err) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("end_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_load_err"}, 32'(load_err), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic chk_good(input string tag);
        chk({tag, "_nwr"}, 32'(wa.size()), 32'd2);
        if (wa.size() >= 2) begin
            chk({tag, "_a0"}, 32'(wa[0]), 32'd0);
            chk({tag, "_d0"}, wd[0], 32'h0050_0013);
            chk({tag, "_a1"}, 32'(wa[1]), 32'd1);
            chk({tag, "_d1"}, wd[1], 32'h00A0_0093);
        end
        chk({tag, "_done"}, 32'(load_done), 32'd1);
        chk({tag, "_err"}, 32'(load_err), 32'd0);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd1);
        chk({tag, "_words"}, 32'(words_loaded), 32'd2);
        chk({tag, "_addr_hold"}, 32'(imem_addr), 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: good two-word image
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00,
                8'hA6, 8'h00, 8'hF0, 8'h00};
        wa.delete(); wd.delete();
        pulse_start();
        chk("c1_ready_after_start", 32'(s_ready), 32'd1);
        send_img(0, -1);
        wait_end();
        chk_good("c1");

        // bytes offered in DONE are refused
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (3) @(negedge clk);
        chk("done_refuse_ready", 32'(s_ready), 32'd0);
        chk("done_refuse_nwr", 32'(wa.size()), 32'd2);
        s_valid = 1'b0;

        // 2: checksum mismatch
        img[13] = 8'h01;
        wa.delete(); wd.delete();
        pulse_start();
        chk("c2_core_rst_low", 32'(core_rst_n), 32'd0);
        chk("c2_done_cleared", 32'(load_done), 32'd0);
        send_img(0, -1);
        wait_end();
        chk("c2_err", 32'(load_err), 32'd1);
        chk("c2_done", 32'(load_done), 32'd0);
        chk("c2_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("c2_nwr", 32'(wa.size()), 32'd2);

        // 3: oversize length
        img = '{8'h01, 8'h01};
        wa.delete(); wd.delete();
        pulse_start();
        chk("c3_err_cleared", 32'(load_err), 32'd0);
        send_img(0, -1);
        chk("c3_err", 32'(load_err), 32'd1);
        chk("c3_ready", 32'(s_ready), 32'd0);
        repeat (4) @(negedge clk);
        chk("c3_nwr", 32'(wa.size()), 32'd0);
        chk("c3_core_rst_n", 32'(core_rst_n), 32'd0);

        // 4: empty image
        img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        wa.delete(); wd.delete();
        pulse_start();
        send_img(0, -1);
        wait_end();
        chk("c4_done", 32'(load_done), 32'd1);
        chk("c4_err", 32'(load_err), 32'd0);
        chk("c4_words", 32'(words_loaded), 32'd0);
        chk("c4_nwr", 32'(wa.size()), 32'd0);
        chk("c4_core_rst_n", 32'(core_rst_n), 32'd1);

        // 5: case 1 with stream gaps and an ignored mid-load start
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00,
                8'hA6, 8'h00, 8'hF0, 8'h00};
        wa.delete(); wd.delete();
        pulse_start();
        send_img(5, 5);
        wait_end();
        chk_good("c5");

        // 6: reset after six data bytes, then a clean reload
        wa.delete(); wd.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(img[i], 0);
        chk("c6_partial_nwr", 32'(wa.size()), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("c6");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wa.delete(); wd.delete();
        pulse_start();
        send_img(0, -1);
        wait_end();
        chk_good("c6r");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
